srt_div_ctrl: RTL
=================

# srt_div_ctrl

Sequencing controller for the radix-4 SRT divider used by the RV32M DIV/DIVU/REM/REMU instructions. It accepts an operation from the execute stage over a valid/ready handshake and handles sign conversion and the two special cases (divide-by-zero, signed overflow). For normal divisions it drives the normalisation pre-processing stage, counts the radix-4 iteration steps, triggers the final correction/shift step, and returns a signed-corrected result over a second valid/ready handshake.

## Interface
Parameters:
- DW, 32, operand/result width
- CW, DW/2, width of iteration count and recovery shift

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of any operation in flight
- in_valid  in  1  operation offered
- in_ready  out  1  high only in IDLE
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- in_a  in  DW  dividend
- in_b  in  DW  divisor
- pp_start  out  1  enable to normalisation stage
- pp_dividend  out  DW  |dividend| (or raw value if unsigned)
- pp_divisor  out  DW  |divisor| (or raw value if unsigned)
- pp_iterations  in  CW  radix-4 step count from normalisation stage
- pp_recovery  in  CW  normalisation shift amount from normalisation stage
- iter_load  out  1  datapath loads normalised operands
- iter_en  out  1  datapath performs one radix-4 step
- fix_en  out  1  datapath performs final correction and de-normalising shift
- fix_shift  out  CW  latched recovery amount, valid while fix_en
- q_mag  in  DW  unsigned quotient magnitude, combinationally valid while fix_en
- r_mag  in  DW  unsigned remainder magnitude, combinationally valid while fix_en
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  DW  final result

## Operation
- States: IDLE, PRE, ITER, FIX, DONE.
- IDLE: in_ready=1. On in_valid, the block latches the op, signed flag (op[0]==0), sign_a, sign_b and the magnitudes (two's-complement abs when signed).
  - Divisor==0 goes to DONE. Result is all-ones for DIV/DIVU, or in_a for REM/REMU.
  - Signed op with a==0x80000000 and b==all-ones goes to DONE. Result is 0x80000000 for DIV, or 0 for REM.
  - All other operations go to PRE.
- PRE (1 cycle):
  - pp_start=1 and iter_load=1.
  - The block latches pp_iterations into a down-counter and pp_recovery into a recovery register, then goes to ITER.
  - A pp_iterations value of 0 is treated as 1.
- ITER: iter_en=1 every cycle and the counter decrements. In the cycle the counter equals 1, the next state is FIX.
- FIX (1 cycle):
  - fix_en=1 and fix_shift=recovery register.
  - The block captures q_mag or r_mag according to op[1].
  - Negation rules: the quotient is negated if the op is signed and sign_a^sign_b; the remainder is negated if the op is signed and sign_a.
  - Next state is DONE.
- DONE: out_valid=1 and out_result is held stable. On out_ready the block returns to IDLE. There is no back-to-back accept in the same cycle.
- pp_dividend/pp_divisor are driven from registers and hold their value from accept until the next accept. pp_start/iter_load/iter_en/fix_en are 0 outside their states.
- flush=1: next state is IDLE from any state and all strobes drop in the following cycle. flush takes priority over in_valid and out_ready. A flush during DONE discards the result.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_result=0, all strobes 0, counter/recovery/pp_* = 0.
- Normal latency, with accept edge at cycle 0:
  - PRE in cycle 1.
  - ITER in cycles 2..N+1, where N=pp_iterations.
  - FIX in cycle N+2.
  - out_valid first high in cycle N+3.
- Special-case latency: out_valid is high in cycle 1.
- Throughput: one operation per N+4 cycles minimum, because the DONE→IDLE hop costs one cycle.
- out_valid stays high with the result unchanged while out_ready=0.

## Test plan
- DIVU a=100, b=7 (pp_iterations=11): out_valid at cycle 14, result 14. iter_en is high exactly 11 cycles and fix_shift=2.
- DIV a=-7, b=2 gives 0xFFFFFFFD. REM a=-7, b=2 gives 0xFFFFFFFF. REMU a=7, b=0x80000000 (N=1) gives 7 at cycle 4.
- DIV/REM by zero with a=0x1234: DIV gives 0xFFFFFFFF at cycle 1 and REM gives 0x1234. pp_start never asserts.
- DIV a=0x80000000, b=0xFFFFFFFF gives 0x80000000, and REM gives 0, both at cycle 1. DIVU with the same operands takes the normal path and gives 0.
- Flush in cycle 5 of an N=11 DIVU: in_ready=1 the next cycle and out_valid never rises. A new DIVU 9/3 accepted then returns 3 correctly.
- Hold out_ready=0 for 10 cycles in DONE: out_result is stable and in_ready=0. Releasing it completes the transfer and in_ready=1 the next cycle. Asserting rst_n low mid-ITER immediately forces in_ready=1 and iter_en=0.

Source files
------------

// File: rtl/srt_div_ctrl.sv
// Sequencing controller for the radix-4 SRT divider (RV32M DIV/DIVU/REM/REMU).
// Handles sign conversion, divide-by-zero and signed-overflow shortcuts, and iteration sequencing.
module srt_div_ctrl #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = DW / 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          pp_start,
  output logic [DW-1:0] pp_dividend,
  output logic [DW-1:0] pp_divisor,
  input  logic [CW-1:0] pp_iterations,
  input  logic [CW-1:0] pp_recovery,
  output logic          iter_load,
  output logic          iter_en,
  output logic          fix_en,
  output logic [CW-1:0] fix_shift,
  input  logic [DW-1:0] q_mag,
  input  logic [DW-1:0] r_mag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

  state_t        r_state;
  state_t        w_next;
  logic          r_in_ready;
  logic          r_pp_start;
  logic          r_iter_load;
  logic          r_iter_en;
  logic          r_fix_en;
  logic          r_out_valid;
  logic [DW-1:0] r_pp_dividend;
  logic [DW-1:0] r_pp_divisor;
  logic [DW-1:0] r_result;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_recovery;
  logic          r_is_rem;
  logic          r_neg_q;
  logic          r_neg_r;

  logic          w_accept;
  logic          w_signed;
  logic          w_sign_a;
  logic          w_sign_b;
  logic [DW-1:0] w_abs_a;
  logic [DW-1:0] w_abs_b;
  logic          w_div_zero;
  logic          w_ovf;
  logic          w_special;
  logic [DW-1:0] w_special_res;
  logic [DW-1:0] w_fix_res;

  // Operand decode and shortcut results, evaluated on the offered operation
  always_comb begin
    w_accept      = (r_state == S_IDLE) && in_valid && !flush;
    w_signed      = ~in_op[0];
    w_sign_a      = w_signed & in_a[DW-1];
    w_sign_b      = w_signed & in_b[DW-1];
    w_abs_a       = w_sign_a ? DW'(~in_a + DW'(1)) : in_a;
    w_abs_b       = w_sign_b ? DW'(~in_b + DW'(1)) : in_b;
    w_div_zero    = (in_b == '0);
    w_ovf         = w_signed && (in_a == INT_MIN) && (&in_b);
    w_special     = w_div_zero || w_ovf;
    if (w_div_zero) begin
      w_special_res = in_op[1] ? in_a : '1;
    end else begin
      w_special_res = in_op[1] ? '0 : INT_MIN;
    end
    if (r_is_rem) begin
      w_fix_res = r_neg_r ? DW'(~r_mag + DW'(1)) : r_mag;
    end else begin
      w_fix_res = r_neg_q ? DW'(~q_mag + DW'(1)) : q_mag;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = w_special ? S_DONE : S_PRE;
      S_PRE:  w_next = S_ITER;
      S_ITER: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // State, strobes decoded from the next state so they are registered, and datapath latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b1;
      r_pp_start    <= 1'b0;
      r_iter_load   <= 1'b0;
      r_iter_en     <= 1'b0;
      r_fix_en      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_pp_dividend <= '0;
      r_pp_divisor  <= '0;
      r_result      <= '0;
      r_cnt         <= '0;
      r_recovery    <= '0;
      r_is_rem      <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_pp_start  <= (w_next == S_PRE);
      r_iter_load <= (w_next == S_PRE);
      r_iter_en   <= (w_next == S_ITER);
      r_fix_en    <= (w_next == S_FIX);
      r_out_valid <= (w_next == S_DONE);
      if (w_accept) begin
        r_pp_dividend <= w_abs_a;
        r_pp_divisor  <= w_abs_b;
        r_is_rem      <= in_op[1];
        r_neg_q       <= w_sign_a ^ w_sign_b;
        r_neg_r       <= w_sign_a;
        if (w_special) r_result <= w_special_res;
      end
      if (r_state == S_PRE) begin
        r_cnt      <= (pp_iterations == '0) ? CW'(1) : pp_iterations;
        r_recovery <= pp_recovery;
      end
      if (r_state == S_ITER) r_cnt <= r_cnt - CW'(1);
      if (r_state == S_FIX && !flush) r_result <= w_fix_res;
    end
  end

  assign in_ready    = r_in_ready;
  assign pp_start    = r_pp_start;
  assign pp_dividend = r_pp_dividend;
  assign pp_divisor  = r_pp_divisor;
  assign iter_load   = r_iter_load;
  assign iter_en     = r_iter_en;
  assign fix_en      = r_fix_en;
  assign fix_shift   = r_recovery;
  assign out_valid   = r_out_valid;
  assign out_result  = r_result;

endmodule
